// File: rtl/core_test_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : core_test_ctrl_if
// Description : Core-facing bus between an RV32I core bench and core_test_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface core_test_ctrl_if #(
    parameter int XLEN = 32
) ();
    logic            retire;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            core_rst;
    logic            done;
    logic            pass;
    logic            timeout;
    logic [XLEN-1:0] fail_code;
    logic [31:0]     cycle_cnt;
    logic [31:0]     instret;

    // Core side: drives retire/store strobes, receives reset and status.
    modport master (
        output retire, mem_we, mem_addr, mem_wdata,
        input  core_rst, done, pass, timeout, fail_code, cycle_cnt, instret
    );

    // Controller side.
    modport slave (
        input  retire, mem_we, mem_addr, mem_wdata,
        output core_rst, done, pass, timeout, fail_code, cycle_cnt, instret
    );
endinterface

`default_nettype wire

// File: rtl/core_test_ctrl.sv
//------------------------------------------------------------------------------
// Module      : core_test_ctrl
// Description : Core reset sequencer, cycle/instret counters and tohost-based
//               end-of-test detection with pass / fail / timeout flags.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module core_test_ctrl #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     RST_CYCLES  = 3,
    parameter int unsigned     MAX_CYCLES  = 1000,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 'h0000_0100
) (
    input  wire              clk,
    input  wire              rst,
    core_test_ctrl_if.slave  bus
);

    localparam int            c_RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_RCW-1:0] c_RST_LAST = c_RCW'(RST_CYCLES - 1);
    localparam logic [31:0]   c_CYC_LAST = 32'(MAX_CYCLES - 1);

    localparam logic [2:0] c_S_RESET   = 3'd0;
    localparam logic [2:0] c_S_RUN     = 3'd1;
    localparam logic [2:0] c_S_PASS    = 3'd2;
    localparam logic [2:0] c_S_FAIL    = 3'd3;
    localparam logic [2:0] c_S_TIMEOUT = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [c_RCW-1:0] r_rst_cnt;
    logic [31:0]      r_cycle_cnt;
    logic [31:0]      r_instret;
    logic [XLEN-1:0]  r_fail_code;
    logic             r_core_rst;
    logic             r_done;
    logic             r_pass;
    logic             r_timeout;

    logic w_core_rst;
    logic w_done;
    logic w_pass;
    logic w_timeout;
    logic w_hit;
    logic w_hit_pass;
    logic w_budget_end;

    // A zero store to tohost is a no-op so the core's own init code can't end the test.
    assign w_hit        = bus.mem_we && (bus.mem_addr == TOHOST_ADDR) && (bus.mem_wdata != '0);
    assign w_hit_pass   = (bus.mem_wdata == XLEN'(1));
    assign w_budget_end = (r_cycle_cnt == c_CYC_LAST);

    // State register plus counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_RESET;
            r_rst_cnt   <= '0;
            r_cycle_cnt <= '0;
            r_instret   <= '0;
            r_fail_code <= '0;
            r_core_rst  <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_core_rst <= w_core_rst;
            r_done     <= w_done;
            r_pass     <= w_pass;
            r_timeout  <= w_timeout;
            if ((r_state == c_S_RESET) && (r_rst_cnt != c_RST_LAST)) begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
            end
            if (r_state == c_S_RUN) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
                r_instret   <= r_instret + 32'(bus.retire);
                if (w_hit && !w_hit_pass) begin
                    r_fail_code <= bus.mem_wdata >> 1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_RESET: begin
                if (r_rst_cnt == c_RST_LAST) begin
                    w_state_nxt = c_S_RUN;
                end
            end
            c_S_RUN: begin
                // A hit on the budget's last edge still reports pass/fail.
                if (w_hit) begin
                    w_state_nxt = w_hit_pass ? c_S_PASS : c_S_FAIL;
                end else if (w_budget_end) begin
                    w_state_nxt = c_S_TIMEOUT;
                end
            end
            c_S_PASS, c_S_FAIL, c_S_TIMEOUT: w_state_nxt = r_state;
            default:                         w_state_nxt = c_S_RESET;
        endcase
    end

    // Decoded from the next state so the flags land in flops on the same edge.
    always_comb begin
        w_core_rst = (w_state_nxt != c_S_RUN);
        w_done     = (w_state_nxt == c_S_PASS) || (w_state_nxt == c_S_FAIL) ||
                     (w_state_nxt == c_S_TIMEOUT);
        w_pass     = (w_state_nxt == c_S_PASS);
        w_timeout  = (w_state_nxt == c_S_TIMEOUT);
    end

    assign bus.core_rst  = r_core_rst;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.timeout   = r_timeout;
    assign bus.fail_code = r_fail_code;
    assign bus.cycle_cnt = r_cycle_cnt;
    assign bus.instret   = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_core_test_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_core_test_ctrl
// Description : Self-checking bench for core_test_ctrl with a behavioural model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_core_test_ctrl;

    localparam int unsigned RST_CYCLES = 3;
    localparam int unsigned MAX_CYCLES = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    core_test_ctrl_if #(.XLEN(32)) bus ();

    core_test_ctrl #(
        .XLEN        (32),
        .RST_CYCLES  (RST_CYCLES),
        .MAX_CYCLES  (MAX_CYCLES),
        .TOHOST_ADDR (32'h0000_0100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase flags and plain counters.
    bit          m_valid    = 1'b0;
    bit          m_in_reset = 1'b1;
    bit          m_finished = 1'b0;
    bit          m_pass     = 1'b0;
    bit          m_timeout  = 1'b0;
    int unsigned m_rst_edges = 0;
    logic [31:0] m_fail_code = '0;
    logic [31:0] m_cyc = '0;
    logic [31:0] m_ins = '0;

    always @(posedge clk) begin
        m_valid = 1'b1;
        if (rst) begin
            m_in_reset  = 1'b1;
            m_finished  = 1'b0;
            m_pass      = 1'b0;
            m_timeout   = 1'b0;
            m_rst_edges = 0;
            m_fail_code = '0;
            m_cyc       = '0;
            m_ins       = '0;
        end else if (m_in_reset) begin
            m_rst_edges++;
            if (m_rst_edges == RST_CYCLES) m_in_reset = 1'b0;
        end else if (!m_finished) begin
            m_cyc = m_cyc + 1;
            if (bus.retire) m_ins = m_ins + 1;
            if (bus.mem_we && bus.mem_addr == 32'h100 && bus.mem_wdata != 0) begin
                m_finished = 1'b1;
                m_pass     = (bus.mem_wdata == 1);
                if (!m_pass) m_fail_code = bus.mem_wdata >> 1;
            end else if (m_cyc == MAX_CYCLES) begin
                m_finished = 1'b1;
                m_timeout  = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("core_rst",  32'(bus.core_rst), 32'(m_in_reset || m_finished));
            chk("done",      32'(bus.done),     32'(m_finished));
            chk("pass",      32'(bus.pass),     32'(m_pass));
            chk("timeout",   32'(bus.timeout),  32'(m_timeout));
            chk("fail_code", bus.fail_code,     m_fail_code);
            chk("cycle_cnt", bus.cycle_cnt,     m_cyc);
            chk("instret",   bus.instret,       m_ins);
        end
    end

    task automatic idle_inputs();
        bus.retire    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic restart();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (RST_CYCLES) @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        // Reset sequence: edge 0 with rst, then core_rst high through edge 3.
        @(negedge clk);
        chk("lit_rst_core_rst", 32'(bus.core_rst), 32'd1);
        chk("lit_rst_done",     32'(bus.done),     32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("lit_edge1_core_rst", 32'(bus.core_rst), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("lit_edge3_core_rst", 32'(bus.core_rst), 32'd0);
        chk("lit_first_run_cyc",  bus.cycle_cnt,     32'd0);

        // Pass: 10 cycles, 7 retiring, tohost=1 on cycle 10.
        for (int i = 0; i < 10; i++) begin
            bus.retire = (i < 7);
            @(negedge clk);
        end
        bus.retire = 1'b0;
        store(32'h100, 32'd1);
        chk("lit_pass_pass",     32'(bus.pass),     32'd1);
        chk("lit_pass_cyc",      bus.cycle_cnt,     32'd11);
        chk("lit_pass_instret",  bus.instret,       32'd7);
        chk("lit_pass_core_rst", 32'(bus.core_rst), 32'd1);
        bus.retire = 1'b1;
        store(32'h100, 32'd7);
        bus.retire = 1'b0;

        // Fail: 0xB -> fail_code 5; later traffic ignored.
        restart();
        repeat (2) @(negedge clk);
        store(32'h100, 32'h0000_000B);
        chk("lit_fail_code", bus.fail_code,    32'd5);
        chk("lit_fail_done", 32'(bus.done),    32'd1);
        chk("lit_fail_pass", 32'(bus.pass),    32'd0);
        store(32'h100, 32'd1);
        store(32'h100, 32'd9);
        chk("lit_fail_hold", bus.fail_code,    32'd5);

        // Ignored writes, then run out the budget.
        restart();
        store(32'h104, 32'd1);
        store(32'h100, 32'd0);
        chk("lit_ign_done", 32'(bus.done), 32'd0);
        chk("lit_ign_cyc",  bus.cycle_cnt, 32'd2);
        begin
            int waited = 0;
            while (!bus.done && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            chk("lit_to_wait_ok", 32'(bus.done), 32'd1);
        end
        chk("lit_to_timeout", 32'(bus.timeout), 32'd1);
        chk("lit_to_cyc",     bus.cycle_cnt,    32'd20);

        // Hit on the budget's final edge wins.
        restart();
        repeat (MAX_CYCLES - 1) @(negedge clk);
        store(32'h100, 32'd1);
        chk("lit_race_pass",    32'(bus.pass),    32'd1);
        chk("lit_race_timeout", 32'(bus.timeout), 32'd0);
        chk("lit_race_cyc",     bus.cycle_cnt,    32'd20);

        // Mid-run reset, then a normal pass run.
        restart();
        bus.retire = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("lit_mid_core_rst", 32'(bus.core_rst), 32'd1);
        chk("lit_mid_cyc",      bus.cycle_cnt,     32'd0);
        chk("lit_mid_instret",  bus.instret,       32'd0);
        bus.retire = 1'b0;
        repeat (RST_CYCLES) @(negedge clk);
        bus.retire = 1'b1;
        repeat (4) @(negedge clk);
        bus.retire = 1'b0;
        store(32'h100, 32'd1);
        chk("lit_mid_pass",    32'(bus.pass), 32'd1);
        chk("lit_mid_instret2", bus.instret,  32'd4);
        chk("lit_mid_cyc2",     bus.cycle_cnt, 32'd5);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected end within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/core_test_ctrl.md
# core_test_ctrl

Parametrised test-control block for the RV32I core benches. It generates the core's reset sequence and counts cycles and retired instructions. It detects end-of-test from a store to a tohost address and flags pass, fail or timeout. The block sits between the bench clock/reset and the core: the bench drives `clk`/`rst` into it, and it drives the core's reset and observes the core's retire and data-memory write strobes.

## Interface
Parameters:
- `XLEN`, 32, data/address width of the observed memory bus
- `RST_CYCLES`, 3, cycles `core_rst` stays high after `rst` falls (≥1)
- `MAX_CYCLES`, 1000, RUN-cycle budget before timeout (≥1)
- `TOHOST_ADDR`, 32'h0000_0100, byte address whose write ends the test

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `retire`  in  1  core retired one instruction this cycle
- `mem_we`  in  1  core data-memory write enable
- `mem_addr`  in  XLEN  core data-memory address
- `mem_wdata`  in  XLEN  core data-memory write data
- `core_rst`  out  1  reset to core, active-high
- `done`  out  1  test finished (any terminal state)
- `pass`  out  1  finished with tohost value 1
- `timeout`  out  1  finished by exhausting `MAX_CYCLES`
- `fail_code`  out  XLEN  `mem_wdata >> 1` of a failing tohost write, else 0
- `cycle_cnt`  out  32  RUN cycles elapsed
- `instret`  out  32  instructions retired during RUN

## Operation
- State machine: RESET, RUN, PASS, FAIL, TIMEOUT. All outputs are registered.
- `rst`=1 at an edge: state RESET, reset counter 0, `cycle_cnt`=`instret`=`fail_code`=0. This takes priority over everything, including during RUN or in terminal states.
- RESET (`core_rst`=1): each edge with `rst`=0 increments the reset counter. When the counter equals `RST_CYCLES-1`, go to RUN.
- RUN (`core_rst`=0): each edge increments `cycle_cnt`, and increments `instret` if `retire`=1.
- The tohost hit is `mem_we`=1 && `mem_addr`==`TOHOST_ADDR` && `mem_wdata`!=0. A write of 0 is ignored and the bench keeps running.
- A hit with `mem_wdata`==1 goes to PASS. Any other nonzero value goes to FAIL with `fail_code`=`mem_wdata>>1`.
- No hit and `cycle_cnt`==`MAX_CYCLES-1` at the edge: go to TIMEOUT.
- Hit and budget expiry on the same edge: the hit wins, and the state is PASS or FAIL.
- The final RUN edge still counts: `cycle_cnt` and `instret` update on that edge like any other RUN edge.
- Terminal states (PASS/FAIL/TIMEOUT) hold until `rst`:
  - `done`=1 and `core_rst`=1, which freezes the core;
  - counters and `fail_code` frozen;
  - `retire`/`mem_*` ignored.
- Output decode:
  - `pass`=1 only in PASS;
  - `timeout`=1 only in TIMEOUT;
  - FAIL is `done`&&!`pass`&&!`timeout`.

## Timing
- Reset values: `core_rst`=1, `done`=`pass`=`timeout`=0, `fail_code`=0, `cycle_cnt`=0, `instret`=0.
- `core_rst` stays high for exactly `RST_CYCLES` edges with `rst`=0. It falls after the `RST_CYCLES`-th such edge.
- The first RUN cycle sees `cycle_cnt`=0.
- A hit sampled at edge N gives `done`/`pass`/`fail_code` valid after edge N. `core_rst` rises after the same edge.
- Timeout: with no hit, `done`=`timeout`=1 after the `MAX_CYCLES`-th RUN edge, when `cycle_cnt`=`MAX_CYCLES`.
- `rst` asserted mid-RUN: `core_rst`=1 and counters clear after that edge. The full RESET sequence then repeats.
- Counters are 32-bit and wrap modulo 2^32. This is unreachable for `MAX_CYCLES`<2^32.

## Test plan
- Reset length: `RST_CYCLES`=3, drop `rst` at edge 0 -> `core_rst` high through edge 3, low after; `cycle_cnt`=0 in the first RUN cycle.
- Pass: 10 RUN cycles with `retire`=1 on 7 of them, then a write of 1 to 0x100 on RUN cycle 10 -> `done`=`pass`=1, `cycle_cnt`=11, `instret`=7 (or 8 if `retire` is set that cycle), `core_rst`=1.
- Fail: write 0x0000_000B to 0x100 -> FAIL, `fail_code`=5, `pass`=`timeout`=0; later writes leave everything unchanged.
- Ignored writes: write 1 to 0x104, then write 0 to 0x100 -> stays in RUN with counters advancing.
- Timeout vs hit: `MAX_CYCLES`=20, no hit -> `timeout`=1, `cycle_cnt`=20. Rerun with a write of 1 to 0x100 on RUN cycle 20 -> PASS, `timeout`=0.
- Mid-run reset: assert `rst` 1 cycle at RUN cycle 5 -> all counters 0, `core_rst`=1 for `RST_CYCLES` cycles, then a normal pass run completes.
